// File: rtl/md_pad_poller_if.sv
// Pin and result bundle between the Mega Drive pad poller and the rest of the console.
// master = poller side, slave = pad port / consumer side.
interface md_pad_poller_if;
  logic        enable;
  logic [6:0]  port_in;
  logic [6:0]  port_out;
  logic [6:0]  port_oe;
  logic [11:0] buttons;
  logic        present;
  logic        six_btn;
  logic        valid;

  modport master (
    input  enable, port_in,
    output port_out, port_oe, buttons, present, six_btn, valid
  );

  modport slave (
    output enable, port_in,
    input  port_out, port_oe, buttons, present, six_btn, valid
  );
endinterface

// File: rtl/md_pad_poller.sv
// Polls a real Mega Drive pad through the TH handshake and decodes an active-high button word.
// Define MD_PAD_POLL_SIX_EN for the full 8-phase six-button sequence; otherwise only PH0/PH1 run.
module md_pad_poller #(
  parameter int SETTLE = 100,
  parameter int IDLE   = 106000
) (
  input  logic            clk,
  input  logic            reset,
  md_pad_poller_if.master pad
);

  localparam int CMAX = (IDLE > SETTLE) ? IDLE : SETTLE;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] IDLE_LAST   = CW'(IDLE - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PHASE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

`ifdef MD_PAD_POLL_SIX_EN
  localparam logic [2:0] LAST_PH = 3'd7;
`else
  localparam logic [2:0] LAST_PH = 3'd1;
`endif

  logic [5:0]    sync1_q, sync1_d;
  logic [5:0]    s_q, s_d;
  logic [1:0]    state_q, state_d;
  logic [2:0]    phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          th_q, th_d;
  logic [5:0]    cap0_q, cap0_d;
  logic [5:2]    cap1_q, cap1_d;
`ifdef MD_PAD_POLL_SIX_EN
  logic [3:0]    cap5_q, cap5_d;
  logic [3:0]    cap6_q, cap6_d;
`endif
  logic [11:0]   buttons_q, buttons_d;
  logic          present_q, present_d;
  logic          six_q, six_d;
  logic          valid_q, valid_d;

  logic          pres_w;
  logic          six_w;
  logic [3:0]    ext_w;
  logic [7:0]    base_w;
  logic [11:0]   btn_w;

  // Decode from the captured pin slots, pins are active-low.
  always_comb begin
    pres_w = (cap1_q[3:2] == 2'b00);
    base_w = {~cap1_q[5], ~cap0_q[5], ~cap0_q[4], ~cap1_q[4], ~cap0_q[3:0]};
`ifdef MD_PAD_POLL_SIX_EN
    six_w  = pres_w && (cap5_q == 4'b0000);
    ext_w  = six_w ? {~cap6_q[0], ~cap6_q[1], ~cap6_q[2], ~cap6_q[3]} : 4'b0000;
`else
    six_w  = 1'b0;
    ext_w  = 4'b0000;
`endif
    btn_w  = pres_w ? {ext_w, base_w} : 12'h000;
  end

  always_comb begin
    sync1_d   = pad.port_in[5:0];
    s_d       = sync1_q;
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    th_d      = th_q;
    cap0_d    = cap0_q;
    cap1_d    = cap1_q;
`ifdef MD_PAD_POLL_SIX_EN
    cap5_d    = cap5_q;
    cap6_d    = cap6_q;
`endif
    buttons_d = buttons_q;
    present_d = present_q;
    six_d     = six_q;
    valid_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        th_d = 1'b1;
        if (cnt_q == IDLE_LAST) begin
          cnt_d = '0;
          if (pad.enable) begin
            state_d = ST_PHASE;
            phase_d = 3'd0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_PHASE: begin
        if (!pad.enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          th_d    = 1'b1;
        end else if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          case (phase_q)
            3'd0: cap0_d = s_q;
            3'd1: cap1_d = s_q[5:2];
`ifdef MD_PAD_POLL_SIX_EN
            3'd5: cap5_d = s_q[3:0];
            3'd6: cap6_d = s_q[3:0];
`endif
            default: ;
          endcase
          if (phase_q == LAST_PH) begin
            state_d = ST_DONE;
            th_d    = 1'b1;
          end else begin
            phase_d = phase_q + 3'd1;
            // next phase is odd (TH low) exactly when the current one is even
            th_d    = phase_q[0];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DONE: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        th_d      = 1'b1;
        valid_d   = 1'b1;
        buttons_d = btn_w;
        present_d = pres_w;
        six_d     = six_w;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        th_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 6'h3F;
      s_q       <= 6'h3F;
      state_q   <= ST_IDLE;
      phase_q   <= 3'd0;
      cnt_q     <= '0;
      th_q      <= 1'b1;
      cap0_q    <= 6'h3F;
      cap1_q    <= 4'hF;
`ifdef MD_PAD_POLL_SIX_EN
      cap5_q    <= 4'hF;
      cap6_q    <= 4'hF;
`endif
      buttons_q <= 12'h000;
      present_q <= 1'b0;
      six_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      s_q       <= s_d;
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      th_q      <= th_d;
      cap0_q    <= cap0_d;
      cap1_q    <= cap1_d;
`ifdef MD_PAD_POLL_SIX_EN
      cap5_q    <= cap5_d;
      cap6_q    <= cap6_d;
`endif
      buttons_q <= buttons_d;
      present_q <= present_d;
      six_q     <= six_d;
      valid_q   <= valid_d;
    end
  end

  assign pad.port_out = {th_q, 6'h3F};
  assign pad.port_oe  = 7'b1000000;
  assign pad.buttons  = buttons_q;
  assign pad.present  = present_q;
  assign pad.six_btn  = six_q;
  assign pad.valid    = valid_q;

endmodule

// File: tb/tb_md_pad_poller.sv
// Directed bench for md_pad_poller with a behavioural 3/6-button pad on the port pins.
module tb_md_pad_poller;

  localparam int SETTLE = 8;
  localparam int IDLE   = 64;
`ifdef MD_PAD_POLL_SIX_EN
  localparam bit SIX = 1'b1;
`else
  localparam bit SIX = 1'b0;
`endif
  localparam int NPH    = SIX ? 8 : 2;
  localparam int LAT    = IDLE + NPH * SETTLE + 1;
  localparam int FALLS  = NPH / 2;
  localparam int CUT_PH = SIX ? 3 : 1;
  localparam int RST_PH = SIX ? 5 : 1;

  typedef struct {
    int          mode;     // 0 none, 1 three-button, 2 six-button
    logic [11:0] btn;      // held buttons, active-high
    logic [11:0] exp_six;  // expected buttons, six-button build
    logic [11:0] exp_base; // expected buttons, default build
    logic        exp_pres;
    logic        exp_sixf; // six_btn expected in the six-button build
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  md_pad_poller_if pif ();

  md_pad_poller #(.SETTLE(SETTLE), .IDLE(IDLE)) dut (
    .clk   (clk),
    .reset (reset),
    .pad   (pif)
  );

  always #5 clk = ~clk;

  // Pad model: counts TH falling edges, forgets them after a long TH-high gap.
  int          pad_mode;
  logic [11:0] pad_btn;
  logic        th, th_prev;
  logic [2:0]  nfall, eff;
  int          hi;
  logic [5:0]  pins;

  assign th = pif.port_out[6];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      th_prev <= 1'b1;
      nfall   <= 3'd0;
      hi      <= 0;
    end else begin
      th_prev <= th;
      hi      <= th ? ((hi < 1000) ? hi + 1 : hi) : 0;
      if (th_prev && !th) nfall <= nfall + 3'd1;
      if (th && hi >= 20) nfall <= 3'd0;
    end
  end

  always_comb begin
    eff  = nfall + {2'b00, th_prev & ~th};
    pins = 6'h3F;
    if (pad_mode != 0) begin
      if (th) begin
        if (pad_mode == 2 && eff == 3'd3)
          pins = ~{pad_btn[6], pad_btn[5], pad_btn[8], pad_btn[9], pad_btn[10], pad_btn[11]};
        else
          pins = ~{pad_btn[6], pad_btn[5], pad_btn[3], pad_btn[2], pad_btn[1], pad_btn[0]};
      end else begin
        if (pad_mode == 2 && eff == 3'd3)
          pins = {~pad_btn[7], ~pad_btn[4], 4'b0000};
        else if (pad_mode == 2 && eff == 3'd4)
          pins = {~pad_btn[7], ~pad_btn[4], 4'b1111};
        else
          pins = {~pad_btn[7], ~pad_btn[4], 2'b00, ~pad_btn[1], ~pad_btn[0]};
      end
    end
    pif.port_in = {th, pins};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Cycles until valid is seen (bounded), and TH falling edges along the way.
  task automatic wait_valid(output int lat, output int falls);
    logic tp;
    tp    = pif.port_out[6];
    lat   = 0;
    falls = 0;
    do begin
      tick();
      lat++;
      if (tp && !pif.port_out[6]) falls++;
      tp = pif.port_out[6];
    end while (!pif.valid && lat < 400);
  endtask

  initial begin
    vec_t tbl[7];
    int   lat, falls, nvalid, nlow;
    logic [11:0] e;

    tbl[0] = '{0, 12'h123, 12'h000, 12'h000, 1'b0, 1'b0};
    tbl[1] = '{1, 12'h018, 12'h018, 12'h018, 1'b1, 1'b0};
    tbl[2] = '{2, 12'h980, 12'h980, 12'h080, 1'b1, 1'b1};
    tbl[3] = '{2, 12'h645, 12'h645, 12'h045, 1'b1, 1'b1};
    tbl[4] = '{1, 12'h0EC, 12'h0EC, 12'h0EC, 1'b1, 1'b0};
    tbl[5] = '{2, 12'h000, 12'h000, 12'h000, 1'b1, 1'b1};
    tbl[6] = '{2, 12'hFFF, 12'hFFF, 12'h0FF, 1'b1, 1'b1};

    pif.enable = 1'b0;
    pad_mode   = 0;
    pad_btn    = 12'h000;

    #2 reset = 1'b1;
    #1;
    check("rst_port_out", {25'd0, pif.port_out}, 32'h7F);
    check("rst_port_oe",  {25'd0, pif.port_oe},  32'h40);
    check("rst_buttons",  {20'd0, pif.buttons},  32'h0);
    check("rst_present",  {31'd0, pif.present},  32'h0);
    check("rst_six_btn",  {31'd0, pif.six_btn},  32'h0);
    check("rst_valid",    {31'd0, pif.valid},    32'h0);

    // enable held low: no sequence may start
    do_reset();
    nvalid = 0;
    nlow   = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (pif.valid) nvalid++;
      if (!pif.port_out[6]) nlow++;
    end
    check("dis_valid_cnt", nvalid, 0);
    check("dis_th_low_cnt", nlow, 0);

    pif.enable = 1'b1;
    for (int v = 0; v < 7; v++) begin
      pad_mode = tbl[v].mode;
      pad_btn  = tbl[v].btn;
      do_reset();
      wait_valid(lat, falls);
      e = SIX ? tbl[v].exp_six : tbl[v].exp_base;
      check($sformatf("v%0d_latency", v), lat, LAT);
      check($sformatf("v%0d_th_falls", v), falls, FALLS);
      check($sformatf("v%0d_buttons", v), {20'd0, pif.buttons}, {20'd0, e});
      check($sformatf("v%0d_present", v), {31'd0, pif.present}, {31'd0, tbl[v].exp_pres});
      check($sformatf("v%0d_six_btn", v), {31'd0, pif.six_btn}, {31'd0, SIX & tbl[v].exp_sixf});
      tick();
      check($sformatf("v%0d_valid_1cyc", v), {31'd0, pif.valid}, 32'h0);
    end

    // output hold through IDLE, then poll period
    pad_mode = 2;
    pad_btn  = 12'h980;
    do_reset();
    wait_valid(lat, falls);
    check("hold_first_lat", lat, LAT);
    pad_mode = 1;
    pad_btn  = 12'h018;
    repeat (30) tick();
    check("hold_buttons", {20'd0, pif.buttons}, SIX ? 32'h980 : 32'h080);
    wait_valid(lat, falls);
    check("poll_period", lat + 30, LAT);
    check("period_buttons", {20'd0, pif.buttons}, 32'h018);
    check("period_six_btn", {31'd0, pif.six_btn}, 32'h0);

    // enable dropped mid-sequence
    pad_mode = 2;
    pad_btn  = 12'h980;
    repeat (IDLE + 8 * CUT_PH + 2) tick();
    check("cut_th_before", {31'd0, pif.port_out[6]}, 32'h0);
    pif.enable = 1'b0;
    tick();
    check("cut_th_after", {31'd0, pif.port_out[6]}, 32'h1);
    check("cut_no_valid", {31'd0, pif.valid}, 32'h0);
    pif.enable = 1'b1;
    check("cut_buttons_held", {20'd0, pif.buttons}, 32'h018);
    wait_valid(lat, falls);
    check("cut_restart_lat", lat, LAT);
    check("cut_new_buttons", {20'd0, pif.buttons}, SIX ? 32'h980 : 32'h080);

    // reset mid-sequence
    repeat (IDLE + 8 * RST_PH + 3) tick();
    reset = 1'b1;
    #1;
    check("mrst_port_out", {25'd0, pif.port_out}, 32'h7F);
    check("mrst_buttons",  {20'd0, pif.buttons},  32'h0);
    check("mrst_present",  {31'd0, pif.present},  32'h0);
    check("mrst_six_btn",  {31'd0, pif.six_btn},  32'h0);
    check("mrst_valid",    {31'd0, pif.valid},    32'h0);
    @(negedge clk);
    reset = 1'b0;
    wait_valid(lat, falls);
    check("mrst_first_lat", lat, LAT);
    check("mrst_buttons_new", {20'd0, pif.buttons}, SIX ? 32'h980 : 32'h080);
    check("mrst_six_new", {31'd0, pif.six_btn}, {31'd0, SIX});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/md_pad_poller.md
# md_pad_poller

Console-side reader for a real Mega Drive / Genesis controller on an external port, such as the SNAC user port. It drives TH and samples the six data pins through the standard 3/6-button TH handshake at a fixed poll rate. It decodes the pin states into an active-high button word, plus presence and six-button flags. Its outputs feed the same P*_ button inputs that the pad emulation consumes.

## Interface
Parameters:
- SETTLE, default 100: cycles each TH phase is held before sampling; minimum 4.
- IDLE, default 106000: cycles between sequences, about 2 ms at 53.69 MHz. It must exceed the pad's 1.5 ms counter-reset timeout.

Ports (reset is asynchronous, active-high; one clock):
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- enable, input, 1: allows polling; when low the block holds in IDLE.
- port_in, input, 7: raw pins {TH,TR,TL,D3,D2,D1,D0}, active-low buttons, pulled high when nothing is attached.
- port_out, output, 7: pin drive values; bit 6 is TH, bits 5:0 are always 1.
- port_oe, output, 7: per-pin output enable; constant 7'b1000000 (this block drives TH only).
- buttons, output, 12: active-high {Z,Y,X,MODE,START,C,B,A,RIGHT,LEFT,DOWN,UP}.
- present, output, 1: a pad was detected in the last completed sequence.
- six_btn, output, 1: the pad answered the six-button ID phase.
- valid, output, 1: one-cycle strobe when buttons, present and six_btn update.

## Operation
- Input path: port_in passes through a 2-flop synchronizer; all sampling uses the synchronized value `s`.
- IDLE state:
  - TH=1.
  - The counter runs to IDLE-1.
  - At that point, if enable=1, go to PH0; otherwise the counter restarts.
- PHn states, n=0..7:
  - TH = 1 for even n, 0 for odd n.
  - The phase counter runs 0..SETTLE-1.
  - On the last cycle, capture `s[5:0]` into the phase n slot and advance.
  - After PH7, go to DONE.
- Decode, with pins inverted to active-high:
  - PH0: UP=~s0, DOWN=~s1, LEFT=~s2, RIGHT=~s3, B=~s4, C=~s5.
  - PH1: A=~s4, START=~s5.
  - present = (PH1 s[3:2]==2'b00).
  - six_btn = present && (PH5 s[3:0]==4'b0000).
  - PH6: Z=~s0, Y=~s1, X=~s2, MODE=~s3.
  - PH2/3/4/7 are driven but not decoded.
- DONE state:
  - Load the outputs.
  - Pulse valid.
  - Return to IDLE with the counter cleared.
  - If present=0, buttons=0.
  - If six_btn=0, bits 11:8 are 0.
- enable falls mid-sequence:
  - Abort to IDLE immediately with TH=1.
  - No valid pulse; outputs hold their previous values.
- Output hold: outputs change only in DONE or reset.

## Timing
- Reset values:
  - port_out=7'h7F.
  - port_oe=7'b1000000.
  - buttons=0, present=0, six_btn=0, valid=0.
  - FSM in IDLE with the counter at 0.
- First sequence starts IDLE cycles after reset release, provided enable=1.
- A sequence lasts 8×SETTLE cycles plus one DONE cycle.
- valid is high for exactly one cycle. Outputs are registered and show new values in the same cycle valid is high.
- Sampling point: SETTLE-1 cycles after the TH edge. Pin data must be stable at least 2 cycles before that, because of the synchronizer.
- Poll period: IDLE + 8×SETTLE + 1 cycles.
- TH changes only on phase boundaries, registered and glitch-free.

## Configuration
- MD_PAD_POLL_SIX_EN defined:
  - The full 8-phase sequence runs.
  - six_btn and bits 11:8 are decoded.
- MD_PAD_POLL_SIX_EN undefined:
  - The sequence is PH0, PH1, DONE only (2×SETTLE+1 cycles).
  - six_btn is tied 0; buttons[11:8] are tied 0.
  - presence detection is unchanged.

## Test plan
All tests use SETTLE=8, IDLE=64 and a behavioural pad model.
- No pad (port_in=7'h7F):
  - TH toggles H,L ×4.
  - valid pulses at cycle 64+65.
  - present=0, buttons=0.
- 3-button pad, A+RIGHT held (the model ignores the six-button phases):
  - present=1, six_btn=0.
  - buttons=12'h018.
- 6-button pad, Z+MODE+START held:
  - six_btn=1.
  - buttons=12'h980.
- enable deasserted during PH3:
  - TH returns to 1 the next cycle.
  - No valid pulse; buttons keep the prior value.
  - The next sequence starts after a full IDLE.
- reset asserted during PH5:
  - Immediately port_out=7'h7F and all outputs are 0.
  - After release, the first valid arrives at cycle 129.
- Macro undefined, with the 6-button pad from the six-button test:
  - valid arrives at cycle 64+17.
  - six_btn=0, buttons=12'h080.
